// File: rtl/niu32_mmio_ctrl.sv
// Niu32 MMIO controller: decodes the 0xFFFF_xxxx window, owns HEX/LEDR/LEDG latches, debounces KEY/SW.
// Latency: writes land on the next edge; read data and error pulse are registered one cycle after the strobe.
// Backpressure: none; every strobe is accepted in its own cycle and the core never waits.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset (release assumed synchronous to clk)
//   io_addr, io_wdata   byte address and store data from the core
//   io_we, io_re        one-cycle store / load strobes
//   io_hit              combinational: address lies inside the 0xFFFF_xxxx window
//   io_rdata, io_err    registered load data (holds between loads) and unmapped-access pulse
//   key_n, sw           raw asynchronous board inputs (keys active-low)
//   hex_val, ledr, ledg output latches to the board

// Per-bit debouncer on already-synchronised inputs.
// Latency: DEB_CYCLES consecutive differing cycles before level follows din.
// Backpressure: none.
module niu32_mmio_debounce #(
  parameter int W          = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_BITS   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,    // synchronised input
  output logic [W-1:0] level,  // debounced level
  output logic [W-1:0] rise    // level goes 0->1 on the coming edge
);

  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [DEB_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt      <= '0;
        level[i] <= 1'b0;
      end else if (din[i] == level[i]) begin
        cnt <= '0;
      end else if (cnt >= DEB_LAST) begin
        // The ">=" keeps the counter from ever running past the threshold,
        // so it cannot wrap back to zero.
        level[i] <= din[i];
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // Decoded in the same cycle the level update is decided, so the sticky
    // edge flag sets on the very edge that the level goes high.
    assign rise[i] = ~level[i] & din[i] & (cnt >= DEB_LAST);
  end

endmodule

module niu32_mmio_ctrl #(
  parameter int                    WORD_SIZE    = 32,
  parameter int                    DEB_CYCLES   = 50000,
  parameter int                    DEB_BITS     = 16,
  parameter logic [WORD_SIZE-1:0]  ADDR_HEX     = 32'hFFFF0000,
  parameter logic [WORD_SIZE-1:0]  ADDR_LEDR    = 32'hFFFF0020,
  parameter logic [WORD_SIZE-1:0]  ADDR_LEDG    = 32'hFFFF0040,
  parameter logic [WORD_SIZE-1:0]  ADDR_KEY     = 32'hFFFF0100,
  parameter logic [WORD_SIZE-1:0]  ADDR_KEYEDGE = 32'hFFFF0104,
  parameter logic [WORD_SIZE-1:0]  ADDR_SWITCH  = 32'hFFFF0120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] io_addr,
  input  logic [WORD_SIZE-1:0] io_wdata,
  input  logic                 io_we,
  input  logic                 io_re,
  output logic                 io_hit,
  output logic [WORD_SIZE-1:0] io_rdata,
  output logic                 io_err,
  input  logic [3:0]           key_n,
  input  logic [9:0]           sw,
  output logic [15:0]          hex_val,
  output logic [9:0]           ledr,
  output logic [7:0]           ledg
);

  // ---------------------------------------------------------------------------
  // Input synchronisers: two flops per bit. Keys preset to "released".
  // ---------------------------------------------------------------------------
  logic [3:0] key_s1, key_s2;
  logic [9:0] sw_s1, sw_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce. Keys are inverted before debouncing so level 1 means pressed.
  // ---------------------------------------------------------------------------
  logic [3:0] key_lvl, key_rise;
  logic [9:0] sw_lvl;
  logic [9:0] sw_rise_unused;

  niu32_mmio_debounce #(
    .W(4), .DEB_CYCLES(DEB_CYCLES), .DEB_BITS(DEB_BITS)
  ) u_key_deb (
    .clk  (clk),
    .reset(reset),
    .din  (~key_s2),
    .level(key_lvl),
    .rise (key_rise)
  );

  niu32_mmio_debounce #(
    .W(10), .DEB_CYCLES(DEB_CYCLES), .DEB_BITS(DEB_BITS)
  ) u_sw_deb (
    .clk  (clk),
    .reset(reset),
    .din  (sw_s2),
    .level(sw_lvl),
    .rise (sw_rise_unused)
  );

  // ---------------------------------------------------------------------------
  // Address decode: full-width compares, so e.g. ADDR_HEX+4 is unmapped.
  // ---------------------------------------------------------------------------
  logic sel_hex, sel_ledr, sel_ledg, sel_key, sel_kedge, sel_sw, sel_any;

  assign io_hit    = (io_addr[WORD_SIZE-1 -: 16] == 16'hFFFF);
  assign sel_hex   = (io_addr == ADDR_HEX);
  assign sel_ledr  = (io_addr == ADDR_LEDR);
  assign sel_ledg  = (io_addr == ADDR_LEDG);
  assign sel_key   = (io_addr == ADDR_KEY);
  assign sel_kedge = (io_addr == ADDR_KEYEDGE);
  assign sel_sw    = (io_addr == ADDR_SWITCH);
  assign sel_any   = sel_hex | sel_ledr | sel_ledg | sel_key | sel_kedge | sel_sw;

  // ---------------------------------------------------------------------------
  // Read mux (pre-write values: reads sample the current register contents).
  // ---------------------------------------------------------------------------
  logic [3:0]           key_edge;
  logic [WORD_SIZE-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (sel_hex)   rd_val = WORD_SIZE'(hex_val);
    if (sel_ledr)  rd_val = WORD_SIZE'(ledr);
    if (sel_ledg)  rd_val = WORD_SIZE'(ledg);
    if (sel_key)   rd_val = WORD_SIZE'(key_lvl);
    if (sel_kedge) rd_val = WORD_SIZE'(key_edge);
    if (sel_sw)    rd_val = WORD_SIZE'(sw_lvl);
  end

  // Write-one-to-clear mask for the sticky edge flags.
  logic [3:0] kedge_clr;
  assign kedge_clr = (io_we && sel_kedge) ? io_wdata[3:0] : 4'h0;

  // ---------------------------------------------------------------------------
  // Registered state: output latches, edge flags, read data, error pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_val  <= '0;
      ledr     <= '0;
      ledg     <= '0;
      key_edge <= '0;
      io_rdata <= '0;
      io_err   <= 1'b0;
    end else begin
      if (io_we && sel_hex)  hex_val <= io_wdata[15:0];
      if (io_we && sel_ledr) ledr    <= io_wdata[9:0];
      if (io_we && sel_ledg) ledg    <= io_wdata[7:0];

      // Set is OR'd in after the clear so a new press wins over a same-cycle W1C.
      key_edge <= (key_edge & ~kedge_clr) | key_rise;

      // Loads outside the window leave io_rdata untouched.
      if (io_re && io_hit) io_rdata <= rd_val;

      io_err <= (io_we | io_re) & io_hit & ~sel_any;
    end
  end

  // Upper store-data bits have no destination in any register.
  logic unused_wdata;
  assign unused_wdata = ^io_wdata[WORD_SIZE-1:16] ^ ^sw_rise_unused;

endmodule

// File: tb/tb_niu32_mmio_ctrl.sv
// Bench for niu32_mmio_ctrl with a short debounce window (DEB_CYCLES=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_niu32_mmio_ctrl;

  localparam logic [31:0] A_HEX   = 32'hFFFF0000;
  localparam logic [31:0] A_LEDR  = 32'hFFFF0020;
  localparam logic [31:0] A_LEDG  = 32'hFFFF0040;
  localparam logic [31:0] A_KEY   = 32'hFFFF0100;
  localparam logic [31:0] A_KEDGE = 32'hFFFF0104;
  localparam logic [31:0] A_SW    = 32'hFFFF0120;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_addr, io_wdata;
  logic        io_we, io_re;
  logic        io_hit;
  logic [31:0] io_rdata;
  logic        io_err;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] hex_val;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  int total = 0;
  int bad   = 0;

  niu32_mmio_ctrl #(.WORD_SIZE(32), .DEB_CYCLES(4), .DEB_BITS(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_we   (io_we),
    .io_re   (io_re),
    .io_hit  (io_hit),
    .io_rdata(io_rdata),
    .io_err  (io_err),
    .key_n   (key_n),
    .sw      (sw),
    .hex_val (hex_val),
    .ledr    (ledr),
    .ledg    (ledg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [15:0] exp_hex;
    logic [9:0]  exp_ledr;
    logic [7:0]  exp_ledg;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives one access, samples io_hit before the edge,
  // then returns at the following negedge with registered outputs sampled.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic hit,
                        output logic [31:0] rd, output logic err);
    io_we = we; io_re = re; io_addr = addr; io_wdata = wdata;
    #1 hit = io_hit;
    @(negedge clk);
    io_we = 1'b0; io_re = 1'b0;
    rd  = io_rdata;
    err = io_err;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic h, e;
    logic [31:0] r;
    access(1'b0, 1'b1, addr, 32'h0, h, r, e);
    chk(name, r, exp);
    chk({name, "_err"}, {31'h0, e}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic h, e;
    logic [31:0] r;
    access(1'b1, 1'b0, addr, data, h, r, e);
  endtask

  initial begin
    logic        h, e;
    logic [31:0] r;

    vecs[0]  = '{1'b1, 1'b0, A_HEX,   32'h0000BEEF, 1'b1, 1'b0, 32'h0,    16'hBEEF, 10'h0,   8'h00};
    vecs[1]  = '{1'b0, 1'b1, A_HEX,   32'h0,        1'b1, 1'b0, 32'hBEEF, 16'hBEEF, 10'h0,   8'h00};
    vecs[2]  = '{1'b1, 1'b0, A_LEDR,  32'hFFFFFFFF, 1'b1, 1'b0, 32'hBEEF, 16'hBEEF, 10'h3FF, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, A_LEDR,  32'h0,        1'b1, 1'b0, 32'h3FF,  16'hBEEF, 10'h3FF, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, A_LEDG,  32'h12345678, 1'b1, 1'b0, 32'h3FF,  16'hBEEF, 10'h3FF, 8'h78};
    vecs[5]  = '{1'b0, 1'b1, A_LEDG,  32'h0,        1'b1, 1'b0, 32'h78,   16'hBEEF, 10'h3FF, 8'h78};
    vecs[6]  = '{1'b1, 1'b1, A_HEX,   32'h00001234, 1'b1, 1'b0, 32'hBEEF, 16'h1234, 10'h3FF, 8'h78};
    vecs[7]  = '{1'b0, 1'b1, A_HEX,   32'h0,        1'b1, 1'b0, 32'h1234, 16'h1234, 10'h3FF, 8'h78};
    vecs[8]  = '{1'b0, 1'b1, 32'h00000100, 32'h0,   1'b0, 1'b0, 32'h1234, 16'h1234, 10'h3FF, 8'h78};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFF0004, 32'h0,   1'b1, 1'b1, 32'h0,    16'h1234, 10'h3FF, 8'h78};
    vecs[10] = '{1'b1, 1'b0, 32'h00000100, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 16'h1234, 10'h3FF, 8'h78};
    vecs[11] = '{1'b1, 1'b0, A_SW,    32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,    16'h1234, 10'h3FF, 8'h78};
    vecs[12] = '{1'b0, 1'b1, A_SW,    32'h0,        1'b1, 1'b0, 32'h0,    16'h1234, 10'h3FF, 8'h78};
    vecs[13] = '{1'b0, 1'b1, A_KEY,   32'h0,        1'b1, 1'b0, 32'h0,    16'h1234, 10'h3FF, 8'h78};
    vecs[14] = '{1'b0, 1'b1, A_KEDGE, 32'h0,        1'b1, 1'b0, 32'h0,    16'h1234, 10'h3FF, 8'h78};
    vecs[15] = '{1'b1, 1'b0, 32'hFFFF0044, 32'hAA,  1'b1, 1'b1, 32'h0,    16'h1234, 10'h3FF, 8'h78};
    vecs[16] = '{1'b0, 1'b0, A_HEX,   32'h0,        1'b1, 1'b0, 32'h0,    16'h1234, 10'h3FF, 8'h78};

    reset = 1'b1; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    key_n = 4'hF; sw = 10'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_hex",   {16'h0, hex_val}, 32'h0);
    chk("rst_ledr",  {22'h0, ledr},    32'h0);
    chk("rst_ledg",  {24'h0, ledg},    32'h0);
    chk("rst_rdata", io_rdata,         32'h0);
    chk("rst_err",   {31'h0, io_err},  32'h0);

    // Register map, W/R, same-cycle RW, unmapped and out-of-window accesses
    for (int i = 0; i < 17; i++) begin
      access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, h, r, e);
      chk($sformatf("v%0d_hit", i),   {31'h0, h},              {31'h0, vecs[i].exp_hit});
      chk($sformatf("v%0d_err", i),   {31'h0, e},              {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), r,                       vecs[i].exp_rd);
      chk($sformatf("v%0d_hex", i),   {16'h0, hex_val},        {16'h0, vecs[i].exp_hex});
      chk($sformatf("v%0d_ledr", i),  {22'h0, ledr},           {22'h0, vecs[i].exp_ledr});
      chk($sformatf("v%0d_ledg", i),  {24'h0, ledg},           {24'h0, vecs[i].exp_ledg});
    end

    // Glitch of 3 cycles on key2 must not propagate
    key_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    key_n[2] = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("glitch_key",   A_KEY,   32'h0);
    rd_chk("glitch_kedge", A_KEDGE, 32'h0);

    // Held press: level changes on the 6th edge (2 sync + 4 debounce)
    key_n[2] = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("press_key_edge5", A_KEY,   32'h0);
    rd_chk("press_key_edge6", A_KEY,   32'h4);
    rd_chk("press_kedge",     A_KEDGE, 32'h4);
    key_n[2] = 1'b1;
    repeat (10) @(negedge clk);

    // W1C of one flag, release not captured, then W1C colliding with a new press
    key_n[0] = 1'b0;
    repeat (8) @(negedge clk);
    rd_chk("k0_kedge", A_KEDGE, 32'h5);
    rd_chk("k0_key",   A_KEY,   32'h1);
    wr(A_KEDGE, 32'h1);
    rd_chk("w1c_kedge", A_KEDGE, 32'h4);
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("release_kedge", A_KEDGE, 32'h4);
    rd_chk("release_key",   A_KEY,   32'h0);
    key_n[0] = 1'b0;
    repeat (5) @(negedge clk);
    wr(A_KEDGE, 32'h1);
    rd_chk("setwins_kedge", A_KEDGE, 32'h5);
    key_n[0] = 1'b1;

    // Switch debounce, writes to read-only registers ignored without error
    sw = 10'h2A5;
    repeat (6) @(negedge clk);
    rd_chk("sw_level", A_SW, 32'h2A5);
    access(1'b1, 1'b0, A_SW, 32'hFFFFFFFF, h, r, e);
    chk("sw_wr_err", {31'h0, e}, 32'h0);
    rd_chk("sw_after_wr", A_SW, 32'h2A5);
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-debounce with a key held across release
    key_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_ledr",  {22'h0, ledr},    32'h0);
    chk("arst_hex",   {16'h0, hex_val}, 32'h0);
    chk("arst_rdata", io_rdata,         32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post_rst_kedge", A_KEDGE, 32'h0);
    repeat (4) @(negedge clk);
    rd_chk("post_rst_key_edge6", A_KEY,   32'h0);
    rd_chk("post_rst_key_edge7", A_KEY,   32'h2);
    rd_chk("post_rst_kedge_set", A_KEDGE, 32'h2);
    key_n[1] = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
